button_events: RTL and testbench
================================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, SHALL set the stable-level time in clock cycles required to accept a pin change (10 ms at 24 MHz); legal range 2..2^24.
REQ-002 Parameter LONG_CYCLES, default 24000000, SHALL set the held time in cycles after press acceptance before a long-press event (1 s at 24 MHz); legal range 1..2^25.
REQ-003 XTAL_IN  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 BTN_A  input  1  SHALL be an asynchronous button pin, active low; index 0 of all vector outputs.
REQ-006 BTN_B  input  1  SHALL be an asynchronous button pin, active low; index 1 of all vector outputs.
REQ-007 pressed  output  2  SHALL be the debounced button level, 1 = held.
REQ-008 press_evt  output  2  SHALL be a one-cycle pulse on accepted press.
REQ-009 release_evt  output  2  SHALL be a one-cycle pulse on accepted release.
REQ-010 long_evt  output  2  SHALL be a one-cycle pulse when a press reaches LONG_CYCLES.

Function
REQ-011 Each pin SHALL pass through a 2-flop synchronizer; raw_pressed = inverted second flop; nothing downstream SHALL use the pin directly.
REQ-012 Each button SHALL have an independent FSM with states IDLE, DEB_DN, HELD, LONG, DEB_UP, a debounce counter, a long counter and a long_flag bit; buttons share no state.
REQ-013 IDLE: pressed=0; raw_pressed=1 -> DEB_DN with debounce counter=0.
REQ-014 DEB_DN: raw_pressed=0 -> IDLE, no event; else counter increments; at counter=DEBOUNCE_CYCLES-1 with raw_pressed=1 -> HELD, press_evt pulses, pressed=1, long counter=0, long_flag=0.
REQ-015 HELD: raw_pressed=0 -> DEB_UP with debounce counter=0; else long counter increments; at long counter=LONG_CYCLES-1 -> LONG, long_evt pulses, long_flag=1.
REQ-016 LONG: raw_pressed=0 -> DEB_UP with debounce counter=0; long counter frozen; no further long_evt for this press.
REQ-017 DEB_UP: pressed stays 1, long counter frozen; raw_pressed=1 -> HELD if long_flag=0, LONG if long_flag=1, no event; else counter increments; at DEBOUNCE_CYCLES-1 -> IDLE, release_evt pulses, pressed=0.
REQ-018 Latency: pin held low from first sampling edge E SHALL give press_evt high in exactly the cycle after edge E+DEBOUNCE_CYCLES+2; release is symmetric.
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES SHALL produce no event and no change of pressed.
REQ-020 Counters SHALL be sized by clog2 of their parameter and SHALL never wrap; long counter saturates by leaving HELD.
REQ-021 Events on A and B in the same cycle SHALL both be reported; press_evt, release_evt, long_evt of one button are mutually exclusive per cycle.
REQ-022 Each event pulse SHALL be exactly one cycle wide and registered (no combinational path from inputs).

Reset
REQ-023 RST=1 at a rising edge SHALL set synchronizer flops to 1, all FSMs to IDLE, all counters and long_flag to 0, and all outputs to 0 on the next cycle, overriding any transition.
REQ-024 Reset mid-press SHALL emit no release_evt; a pin still held after reset deasserts SHALL produce a fresh press_evt after the REQ-018 latency.
REQ-025 Outputs SHALL be 0 while RST=1 regardless of pin levels.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-026 Clean press: BTN_A low at edge 10, held -> press_evt[0] high only after edge 16, pressed[0]=1 from then; press_evt[1]=0.
REQ-027 Bounce: BTN_B low 3 cycles, high, low 2 cycles, high -> no events, pressed[1]=0 throughout.
REQ-028 Long press: BTN_A held 40 cycles -> press_evt[0], long_evt[0] exactly 16 cycles later, single pulse; release -> release_evt[0] 6 cycles after pin rise.
REQ-029 Release glitch: in LONG, BTN_A high 2 cycles then low -> pressed[0] stays 1, no release_evt, no second long_evt.
REQ-030 Simultaneous: both pins low on the same edge -> press_evt=2'b11 in one cycle.
REQ-031 Reset mid-press: RST pulsed while pressed[0]=1, pin held -> outputs 0, no release_evt, press_evt[0] again 6 cycles after RST falls.

Source files
------------

// File: rtl/button_events_if.sv
// Signal bundle for the two-button debouncer: raw active-low pins in, debounced
// level and one-cycle event pulses out (bit 0 = BTN_A, bit 1 = BTN_B).
interface button_events_if;
  logic       BTN_A;
  logic       BTN_B;
  logic [1:0] pressed;
  logic [1:0] press_evt;
  logic [1:0] release_evt;
  logic [1:0] long_evt;

  modport master (
    output BTN_A, BTN_B,
    input  pressed, press_evt, release_evt, long_evt
  );

  modport slave (
    input  BTN_A, BTN_B,
    output pressed, press_evt, release_evt, long_evt
  );
endinterface

// File: rtl/button_events.sv
// Two independent button debouncers with press, release and long-press events.
// Pins are synchronized, then each button runs its own FSM with registered outputs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | released and stable, waiting for raw press
// DEB_DN | raw press seen, counting stable-low time before accepting
// HELD   | press accepted, counting toward long-press
// LONG   | long-press reported, waiting for release
// DEB_UP | raw release seen, counting stable-high time before accepting
module button_events #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000
) (
  input logic            XTAL_IN,
  input logic            RST,
  button_events_if.slave btn
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DEB_DN = 3'd1;
  localparam logic [2:0] HELD   = 3'd2;
  localparam logic [2:0] LONG   = 3'd3;
  localparam logic [2:0] DEB_UP = 3'd4;

  logic [1:0] pins;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] raw_pressed;

  assign pins = {btn.BTN_B, btn.BTN_A};

  // Synchronizer resets to the released (high) pin level.
  always_ff @(posedge XTAL_IN) begin
    if (RST) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  assign raw_pressed = ~sync2;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [2:0]        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [LONG_W-1:0] long_cnt;
    logic              long_flag;
    logic              pressed_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;

    always_ff @(posedge XTAL_IN) begin
      if (RST) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        long_cnt  <= '0;
        long_flag <= 1'b0;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (state)
          IDLE: begin
            if (raw_pressed[i]) begin
              state   <= DEB_DN;
              deb_cnt <= '0;
            end
          end
          DEB_DN: begin
            if (!raw_pressed[i]) begin
              state <= IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= HELD;
              press_r   <= 1'b1;
              pressed_r <= 1'b1;
              long_cnt  <= '0;
              long_flag <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end
          HELD: begin
            if (!raw_pressed[i]) begin
              state   <= DEB_UP;
              deb_cnt <= '0;
            end else if (long_cnt == LONG_LAST) begin
              state     <= LONG;
              long_r    <= 1'b1;
              long_flag <= 1'b1;
            end else begin
              long_cnt <= long_cnt + LONG_ONE;
            end
          end
          LONG: begin
            if (!raw_pressed[i]) begin
              state   <= DEB_UP;
              deb_cnt <= '0;
            end
          end
          DEB_UP: begin
            // A bounce back to pressed resumes where it left off; long_cnt was frozen.
            if (raw_pressed[i]) begin
              state <= long_flag ? LONG : HELD;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= IDLE;
              release_r <= 1'b1;
              pressed_r <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign btn.pressed[i]     = pressed_r;
    assign btn.press_evt[i]   = press_r;
    assign btn.release_evt[i] = release_r;
    assign btn.long_evt[i]    = long_r;
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Each step drives pins/reset, advances one clock and compares all outputs.
module tb_button_events;

  logic XTAL_IN;
  logic RST;
  int   checks;
  int   errors;

  button_events_if bus ();

  button_events #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16)
  ) dut (
    .XTAL_IN(XTAL_IN),
    .RST    (RST),
    .btn    (bus)
  );

  initial XTAL_IN = 1'b0;
  always #5 XTAL_IN = ~XTAL_IN;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={prs,pevt,revt,levt}=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [1:0] prs, input logic [1:0] pe,
                                      input logic [1:0] re, input logic [1:0] le);
    return {prs, pe, re, le};
  endfunction

  // Drive levels for the next rising edge, then sample on the falling edge.
  task automatic step(input string tag, input int t, input logic a, input logic b,
                      input logic rst, input logic [7:0] exp);
    bus.BTN_A = a;
    bus.BTN_B = b;
    RST       = rst;
    @(posedge XTAL_IN);
    @(negedge XTAL_IN);
    check($sformatf("%s t=%0d", tag, t),
          {bus.pressed, bus.press_evt, bus.release_evt, bus.long_evt}, exp);
  endtask

  initial begin
    logic       a;
    logic       b;
    logic       r;
    logic [1:0] prs;
    logic [1:0] pe;
    logic [1:0] re;
    logic [1:0] le;
    checks = 0;
    errors = 0;
    bus.BTN_A = 1'b1;
    bus.BTN_B = 1'b1;
    RST       = 1'b1;

    // Reset with pins held low, then pins high, then released: all outputs stay 0.
    for (int t = 1; t <= 10; t++) begin
      a = (t > 3);
      r = (t <= 5);
      step("reset", t, a, a, r, 8'h00);
    end

    // Clean long press on A: press at +6, long 16 later, release 6 after pin rise.
    for (int t = 1; t <= 55; t++) begin
      a   = (t > 40);
      prs = {1'b0, (t >= 7 && t < 47)};
      pe  = {1'b0, (t == 7)};
      re  = {1'b0, (t == 47)};
      le  = {1'b0, (t == 23)};
      step("long_a", t, a, 1'b1, 1'b0, pack(prs, pe, re, le));
    end

    // Bounce on B: 3 low/1 high/2 low, later 4 low (one short of acceptance).
    for (int t = 1; t <= 25; t++) begin
      b = !((t >= 1 && t <= 3) || (t >= 5 && t <= 6) || (t >= 12 && t <= 15));
      step("bounce_b", t, 1'b1, b, 1'b0, 8'h00);
    end

    // Shortest accepted press on A: 5 cycles low.
    for (int t = 1; t <= 16; t++) begin
      a   = (t > 5);
      prs = {1'b0, (t >= 7 && t < 12)};
      pe  = {1'b0, (t == 7)};
      re  = {1'b0, (t == 12)};
      step("min_press_a", t, a, 1'b1, 1'b0, pack(prs, pe, re, 2'b00));
    end

    // Release glitch on A while in LONG: no release, no second long.
    for (int t = 1; t <= 58; t++) begin
      a   = (t == 30 || t == 31 || t >= 46);
      prs = {1'b0, (t >= 7 && t < 52)};
      pe  = {1'b0, (t == 7)};
      re  = {1'b0, (t == 52)};
      le  = {1'b0, (t == 23)};
      step("glitch_long_a", t, a, 1'b1, 1'b0, pack(prs, pe, re, le));
    end

    // Release glitch on B while in HELD: long counter pauses 3 edges, long at 26.
    for (int t = 1; t <= 46; t++) begin
      b   = (t == 10 || t == 11 || t >= 36);
      prs = {(t >= 7 && t < 42), 1'b0};
      pe  = {(t == 7), 1'b0};
      re  = {(t == 42), 1'b0};
      le  = {(t == 26), 1'b0};
      step("glitch_held_b", t, 1'b1, b, 1'b0, pack(prs, pe, re, le));
    end

    // Both pins pressed and released on the same edges.
    for (int t = 1; t <= 20; t++) begin
      a   = (t > 10);
      prs = {2{(t >= 7 && t < 17)}};
      pe  = {2{(t == 7)}};
      re  = {2{(t == 17)}};
      step("simul", t, a, a, 1'b0, pack(prs, pe, re, 2'b00));
    end

    // Reset pulse mid-press on A with the pin still held: fresh press, no release.
    for (int t = 1; t <= 34; t++) begin
      a   = (t >= 25);
      r   = (t == 10);
      prs = {1'b0, ((t >= 7 && t < 10) || (t >= 17 && t < 31))};
      pe  = {1'b0, (t == 7 || t == 17)};
      re  = {1'b0, (t == 31)};
      step("reset_mid", t, a, 1'b1, r, pack(prs, pe, re, 2'b00));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
